vga_timing_gen: RTL

//   Raster timing generator for the VGA output path: divides the board clock to a pixel tick,

---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-tick divider, horizontal/vertical counters and
// registered sync/blank outputs that always describe the same pixel as x/y.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds kept 11 bits wide so an end bound of exactly 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic             running;
  logic [DIV_W-1:0] div_cnt;

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       blank_n_nxt;

  // The divider only starts on the first edge after reset release, so the first
  // pixel tick arrives CLK_DIV clocks after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (running) begin
      if (pix_en) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign pix_en = running && (div_cnt == DIV_LAST);

  // Low for the first half of each pixel, so the DAC's rising edge lands mid-pixel.
  generate
    if (CLK_DIV == 1) begin : g_vga_clk_direct
      assign vga_clk = running;
    end else begin : g_vga_clk_div
      assign vga_clk = running && (div_cnt >= DIV_HALF);
    end
  endgenerate

  always_comb begin
    x_wrap = (x == H_LAST);
    y_wrap = (y == V_LAST);
    x_nxt  = x_wrap ? 10'd0 : x + 10'd1;
    y_nxt  = y;
    if (x_wrap) begin
      y_nxt = y_wrap ? 10'd0 : y + 10'd1;
    end
  end

  // Decode from the next coordinates so the registered syncs line up with x/y.
  always_comb begin
    hsync_nxt   = !(({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END));
    vsync_nxt   = !(({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END));
    blank_n_nxt = ({1'b0, x_nxt} < H_ACT_END) && ({1'b0, y_nxt} < V_ACT_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b1;
    end else if (pix_en) begin
      x       <= x_nxt;
      y       <= y_nxt;
      hsync   <= hsync_nxt;
      vsync   <= vsync_nxt;
      blank_n <= blank_n_nxt;
    end
  end

  // Only an actual wrap to (0,0) pulses; coming out of reset at (0,0) does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && x_wrap && y_wrap;
    end
  end

  assign sync_n = 1'b0;

endmodule
